// File: rtl/generic_bus_latency_shim.sv
// Wait-state injector between the L1 cache generic_bus port and the memory model.
// Define GENERIC_BUS_SHIM_RANDLAT_EN to add LFSR-driven random extra latency.
module generic_bus_latency_shim #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LATENCY   = 4,
    parameter logic [3:0]  RAND_MASK = 4'hF
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [ADDR_W-1:0]   up_addr,
    input  logic [DATA_W-1:0]   up_wdata,
    input  logic [DATA_W/8-1:0] up_byte_en,
    input  logic                up_ren,
    input  logic                up_wen,
    output logic [DATA_W-1:0]   up_rdata,
    output logic                up_busy,
    output logic [ADDR_W-1:0]   dn_addr,
    output logic [DATA_W-1:0]   dn_wdata,
    output logic [DATA_W/8-1:0] dn_byte_en,
    output logic                dn_ren,
    output logic                dn_wen,
    input  logic [DATA_W-1:0]   dn_rdata,
    input  logic                dn_busy,
    output logic                protocol_err,
    output logic [15:0]         txn_cnt
);

    // Counter must hold LATENCY plus the largest random extra (15).
    localparam int unsigned CNT_W = $clog2(LATENCY + 17);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ISSUE,
        RESP
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_dec;
    logic [CNT_W-1:0] wait_load;
    logic [3:0]       rand_bits;
    logic             op_wr;
    logic             req;
    logic             accept;

    assign req      = up_ren | up_wen;
    assign accept   = (state == IDLE) && req;
    assign wait_dec = wait_cnt - CNT_W'(1);

`ifdef GENERIC_BUS_SHIM_RANDLAT_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Current value sets this request's extra latency; it then advances.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lfsr <= 16'hACE1;
        end else if (accept) begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    assign rand_bits = lfsr[3:0];
`else
    assign rand_bits = '0;
`endif

    assign wait_load = CNT_W'(LATENCY) + CNT_W'(rand_bits & RAND_MASK);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nx = (wait_load == '0) ? ISSUE : WAIT;
                end
            end
            WAIT: begin
                // Cache withdrawing its request cancels before anything reaches memory.
                if (!req) begin
                    state_nx = IDLE;
                end else if (wait_dec == '0) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (!dn_busy) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dn_addr      <= '0;
            dn_wdata     <= '0;
            dn_byte_en   <= '0;
            op_wr        <= 1'b0;
            wait_cnt     <= '0;
            up_rdata     <= '0;
            txn_cnt      <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (accept) begin
                dn_addr    <= up_addr;
                dn_wdata   <= up_wdata;
                dn_byte_en <= up_byte_en;
                op_wr      <= up_wen;
                wait_cnt   <= wait_load;
            end
            if (state == WAIT) begin
                wait_cnt <= wait_dec;
            end
            if ((state == ISSUE) && !dn_busy && !op_wr) begin
                up_rdata <= dn_rdata;
            end
            if (state == RESP) begin
                txn_cnt <= txn_cnt + 16'd1;
            end
            if (up_ren && up_wen) begin
                protocol_err <= 1'b1;
            end
        end
    end

    assign dn_ren  = (state == ISSUE) && !op_wr;
    assign dn_wen  = (state == ISSUE) && op_wr;
    assign up_busy = (state != RESP);

endmodule

// File: tb/tb_generic_bus_latency_shim.sv
// Directed scoreboard bench for generic_bus_latency_shim (LATENCY=4).
module tb_generic_bus_latency_shim;

    localparam int LAT = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] up_addr = '0;
    logic [31:0] up_wdata = '0;
    logic [3:0]  up_byte_en = '0;
    logic        up_ren = 1'b0;
    logic        up_wen = 1'b0;
    logic [31:0] up_rdata;
    logic        up_busy;
    logic [31:0] dn_addr;
    logic [31:0] dn_wdata;
    logic [3:0]  dn_byte_en;
    logic        dn_ren;
    logic        dn_wen;
    logic [31:0] dn_rdata;
    logic        dn_busy;
    logic        protocol_err;
    logic [15:0] txn_cnt;

    generic_bus_latency_shim #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .LATENCY  (LAT),
        .RAND_MASK(4'hF)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .up_addr     (up_addr),
        .up_wdata    (up_wdata),
        .up_byte_en  (up_byte_en),
        .up_ren      (up_ren),
        .up_wen      (up_wen),
        .up_rdata    (up_rdata),
        .up_busy     (up_busy),
        .dn_addr     (dn_addr),
        .dn_wdata    (dn_wdata),
        .dn_byte_en  (dn_byte_en),
        .dn_ren      (dn_ren),
        .dn_wen      (dn_wen),
        .dn_rdata    (dn_rdata),
        .dn_busy     (dn_busy),
        .protocol_err(protocol_err),
        .txn_cnt     (txn_cnt)
    );

    always #5 CLK = ~CLK;

    // Memory model: busy for busy_hold ISSUE cycles, data derived from address.
    int busy_hold = 0;
    int iss_cnt;
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) iss_cnt <= 0;
        else if (dn_ren || dn_wen) iss_cnt <= iss_cnt + 1;
        else iss_cnt <= 0;
    end
    assign dn_busy  = (iss_cnt < busy_hold);
    assign dn_rdata = {16'hdada, dn_addr[15:0]};

    int          n_pass = 0;
    int          n_fail = 0;
    int          n_total = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd = '0;
    int          exp_txn = 0;
    logic [15:0] lfsr_m = 16'hACE1;

    int          r_wait, r_lat, r_first, r_nren, r_nwen;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_be;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_wait(output int w);
        w = LAT;
`ifdef GENERIC_BUS_SHIM_RANDLAT_EN
        w = LAT + int'(lfsr_m[3:0]);
        lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
`endif
    endtask

    // Called #1 after a rising edge with the DUT idle; returns #1 after an edge, idle again.
    task automatic do_txn(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be, input int hold);
        busy_hold = hold;
        next_wait(r_wait);
        if (rd && !wr) last_rd = {16'hdada, a[15:0]};
        exp_q.push_back(last_rd);
        up_addr = a; up_wdata = wd; up_byte_en = be; up_ren = rd; up_wen = wr;
        r_lat = -1; r_first = -1; r_nren = 0; r_nwen = 0;
        r_addr = '0; r_wdata = '0; r_be = '0;
        for (int i = 1; i <= 80 && r_lat < 0; i++) begin
            @(posedge CLK); #1;
            if (i == 1) begin
                up_addr = ~a; up_wdata = ~wd; up_byte_en = ~be;
            end
            if (dn_ren || dn_wen) begin
                if (r_first < 0) r_first = i;
                if (dn_ren) r_nren++;
                if (dn_wen) r_nwen++;
                r_addr = dn_addr; r_wdata = dn_wdata; r_be = dn_byte_en;
            end
            if (!up_busy) begin
                r_lat = i;
                check("rdata_sb", up_rdata, exp_q.pop_front());
                exp_txn++;
            end
        end
        if (r_lat < 0) exp_q.delete();
        up_ren = 1'b0; up_wen = 1'b0;
        @(posedge CLK); #1;
    endtask

    initial begin
        int w;
        int seen_iss;
        int seen_resp;

        repeat (2) @(posedge CLK);
        #1;
        check("rst_up_busy", 32'(up_busy), 32'd1);
        check("rst_up_rdata", up_rdata, 32'h0);
        check("rst_dn_ren", 32'(dn_ren), 32'd0);
        check("rst_dn_wen", 32'(dn_wen), 32'd0);
        check("rst_dn_addr", dn_addr, 32'h0);
        check("rst_dn_wdata", dn_wdata, 32'h0);
        check("rst_dn_be", 32'(dn_byte_en), 32'h0);
        check("rst_perr", 32'(protocol_err), 32'd0);
        check("rst_txn", 32'(txn_cnt), 32'd0);
        nRST = 1'b1;
        @(posedge CLK); #1;

        // Write with latched fields; upstream fields scrambled after accept.
        do_txn(1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 4'b0011, 0);
        check("wr_lat", 32'(r_lat), 32'(r_wait + 2));
        check("wr_issue_cycle", 32'(r_first), 32'(r_wait + 1));
        check("wr_nwen", 32'(r_nwen), 32'd1);
        check("wr_nren", 32'(r_nren), 32'd0);
        check("wr_dn_addr", r_addr, 32'h0000_0080);
        check("wr_dn_wdata", r_wdata, 32'hCAFE_F00D);
        check("wr_dn_be", 32'(r_be), 32'h3);
        check("wr_txn", 32'(txn_cnt), 32'(exp_txn));

        // Read: response in cycle LATENCY+2 with memory data.
        do_txn(1'b1, 1'b0, 32'h0000_1234, 32'h0, 4'hF, 0);
        check("rd_lat", 32'(r_lat), 32'(r_wait + 2));
        check("rd_nren", 32'(r_nren), 32'd1);
        check("rd_nwen", 32'(r_nwen), 32'd0);
        check("rd_rdata", up_rdata, 32'hdada_1234);
        check("rd_txn", 32'(txn_cnt), 32'(exp_txn));

        // Memory busy for 3 ISSUE cycles stretches the stall.
        do_txn(1'b1, 1'b0, 32'hABCD_5678, 32'h0, 4'hF, 3);
        check("busy_lat", 32'(r_lat), 32'(r_wait + 5));
        check("busy_issue_cycles", 32'(r_nren), 32'd4);
        check("busy_txn", 32'(txn_cnt), 32'(exp_txn));

        // Abort: up_ren dropped in the second WAIT cycle.
        next_wait(w);
        up_addr = 32'h0000_0777; up_ren = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        up_ren = 1'b0;
        seen_iss = 0; seen_resp = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK); #1;
            if (dn_ren || dn_wen) seen_iss++;
            if (!up_busy) seen_resp++;
        end
        check("abort_issue", 32'(seen_iss), 32'd0);
        check("abort_resp", 32'(seen_resp), 32'd0);
        check("abort_txn", 32'(txn_cnt), 32'(exp_txn));

        // Both enables: write wins, protocol error is sticky.
        do_txn(1'b1, 1'b1, 32'h0000_0044, 32'h1111_2222, 4'hF, 0);
        check("both_nwen", 32'(r_nwen), 32'd1);
        check("both_nren", 32'(r_nren), 32'd0);
        check("both_wdata", r_wdata, 32'h1111_2222);
        check("both_perr", 32'(protocol_err), 32'd1);
        do_txn(1'b1, 1'b0, 32'h9000_00AA, 32'h0, 4'hF, 1);
        check("perr_sticky", 32'(protocol_err), 32'd1);
        check("post_perr_lat", 32'(r_lat), 32'(r_wait + 3));

        // Reset while stuck in ISSUE.
        busy_hold = 20;
        next_wait(w);
        up_addr = 32'h0000_0055; up_ren = 1'b1;
        for (int i = 0; i < 40 && dn_ren !== 1'b1; i++) begin
            @(posedge CLK); #1;
        end
        check("mid_pre_ren", 32'(dn_ren), 32'd1);
        #2 nRST = 1'b0;
        #1;
        check("mid_dn_ren", 32'(dn_ren), 32'd0);
        check("mid_up_busy", 32'(up_busy), 32'd1);
        check("mid_up_rdata", up_rdata, 32'h0);
        check("mid_dn_addr", dn_addr, 32'h0);
        check("mid_perr", 32'(protocol_err), 32'd0);
        check("mid_txn", 32'(txn_cnt), 32'd0);
        up_ren = 1'b0;
        busy_hold = 0;
        exp_txn = 0;
        last_rd = '0;
        lfsr_m = 16'hACE1;
        exp_q.delete();
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(posedge CLK); #1;

        do_txn(1'b1, 1'b0, 32'h0000_2468, 32'h0, 4'hF, 0);
        check("post_rst_lat", 32'(r_lat), 32'(r_wait + 2));
        check("post_rst_rdata", up_rdata, 32'hdada_2468);
        check("post_rst_txn", 32'(txn_cnt), 32'(exp_txn));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
